// File: rtl/ysyx_22050612_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, error codes, FSM states.
package ysyx_22050612_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_MIS = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;

    typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_e;

    // Number of bytes touched by an access of the given size code.
    function automatic logic [3:0] nbytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/ysyx_22050612_lsu_if.sv
// EXU <-> LSU request/response channel and LSU <-> memory bus channel.
interface ysyx_22050612_lsu_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic [1:0]        resp_err;

    // EXU side issues requests and consumes responses.
    modport master (
        output req_valid, req_wen, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    // LSU side accepts requests and produces responses.
    modport slave (
        input  req_valid, req_wen, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface ysyx_22050612_mem_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
);
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wmask;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    // LSU drives bus commands.
    modport master (
        output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata
    );
    // Memory bridge answers them.
    modport slave (
        input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/ysyx_22050612_lsu_align.sv
// Byte-lane steering: places store data/mask on the aligned bus word and
// extracts plus sign/zero-extends load data from it.
module ysyx_22050612_lsu_align
    import ysyx_22050612_lsu_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int MW    = XLEN / 8,
    localparam int OFF_W = $clog2(MW)
) (
    input  logic [OFF_W-1:0] off_i,
    input  logic [1:0]       size_i,
    input  logic             sgn_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [XLEN-1:0]  rdata_i,
    output logic [XLEN-1:0]  wdata_o,
    output logic [MW-1:0]    wmask_o,
    output logic [XLEN-1:0]  rdata_o
);
    logic [MW-1:0]   base;
    logic [XLEN-1:0] sh;

    assign wdata_o = wdata_i << {off_i, 3'b000};
    assign wmask_o = base << off_i;
    assign sh      = rdata_i >> {off_i, 3'b000};

    // Lane mask for the access width and extension of the shifted load word.
    always_comb begin
        base    = '1;
        rdata_o = sh;
        case (size_i)
            SZ_B: begin
                base    = MW'(1);
                rdata_o = sgn_i ? XLEN'($signed(sh[7:0])) : XLEN'(sh[7:0]);
            end
            SZ_H: begin
                base    = MW'(3);
                rdata_o = sgn_i ? XLEN'($signed(sh[15:0])) : XLEN'(sh[15:0]);
            end
            SZ_W: begin
                base    = MW'(15);
                rdata_o = sgn_i ? XLEN'($signed(sh[31:0])) : XLEN'(sh[31:0]);
            end
            default: begin
                base    = '1;
                rdata_o = sh;
            end
        endcase
    end
endmodule

// File: rtl/ysyx_22050612_lsu.sv
// Multi-cycle load/store unit: one outstanding request, aligned lane-masked bus
// access, per-state timeout, registered response held until accepted.
module ysyx_22050612_lsu
    import ysyx_22050612_lsu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int TMO_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_22050612_lsu_if.slave    exu,
    ysyx_22050612_mem_if.master   mem
);
    localparam int MW    = XLEN / 8;
    localparam int OFF_W = $clog2(MW);
    localparam int CW    = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

    state_e            state_q;
    logic [1:0]        size_q;
    logic              sgn_q, wen_q;
    logic [OFF_W-1:0]  off_q;
    logic [CW-1:0]     cnt_q;
    logic              mem_valid_q, mem_wen_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic [MW-1:0]     mem_wmask_q;
    logic              resp_valid_q;
    logic [XLEN-1:0]   resp_rdata_q;
    logic [1:0]        resp_err_q;

    logic [3:0]        nb_req;
    logic              mis_d, tmo_hit, in_idle;
    logic [OFF_W-1:0]  off_d;
    logic [1:0]        size_d;
    logic [CW-1:0]     cnt_inc;
    logic [XLEN-1:0]   wdata_sh, rdata_ext;
    logic [MW-1:0]     wmask_sh;

    assign in_idle = (state_q == IDLE);
    assign nb_req  = nbytes(exu.req_size);
    assign mis_d   = ((exu.req_addr[2:0] & 3'(nb_req - 4'd1)) != 3'd0)
                   || (exu.req_size == SZ_D && XLEN == 32);
    // Timeout fires in the TMO_CYC-th cycle of a wait state; completion that cycle wins.
    assign tmo_hit = (TMO_CYC != 0) && (cnt_q == CW'(TMO_CYC - 1));
    assign cnt_inc = (cnt_q == CW'(TMO_CYC)) ? cnt_q : cnt_q + CW'(1);

    // The lane aligner serves the incoming store in IDLE and the held load in MWAIT.
    assign off_d  = in_idle ? exu.req_addr[OFF_W-1:0] : off_q;
    assign size_d = in_idle ? exu.req_size : size_q;

    ysyx_22050612_lsu_align #(.XLEN(XLEN)) u_align (
        .off_i   (off_d),
        .size_i  (size_d),
        .sgn_i   (sgn_q),
        .wdata_i (exu.req_wdata),
        .rdata_i (mem.mem_rdata),
        .wdata_o (wdata_sh),
        .wmask_o (wmask_sh),
        .rdata_o (rdata_ext)
    );

    assign exu.req_ready  = in_idle;
    assign exu.resp_valid = resp_valid_q;
    assign exu.resp_rdata = resp_rdata_q;
    assign exu.resp_err   = resp_err_q;
    assign mem.mem_valid  = mem_valid_q;
    assign mem.mem_wen    = mem_wen_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_wdata  = mem_wdata_q;
    assign mem.mem_wmask  = mem_wmask_q;

    // Transaction FSM with registered bus command and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            size_q       <= '0;
            sgn_q        <= 1'b0;
            wen_q        <= 1'b0;
            off_q        <= '0;
            cnt_q        <= '0;
            mem_valid_q  <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= ERR_OK;
        end else begin
            case (state_q)
                IDLE: if (exu.req_valid) begin
                    size_q <= exu.req_size;
                    sgn_q  <= exu.req_signed;
                    wen_q  <= exu.req_wen;
                    off_q  <= exu.req_addr[OFF_W-1:0];
                    cnt_q  <= '0;
                    if (mis_d) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                        resp_err_q   <= ERR_MIS;
                        state_q      <= RESP;
                    end else begin
                        mem_valid_q <= 1'b1;
                        mem_wen_q   <= exu.req_wen;
                        mem_addr_q  <= {exu.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        mem_wdata_q <= wdata_sh;
                        mem_wmask_q <= exu.req_wen ? wmask_sh : '0;
                        state_q     <= MREQ;
                    end
                end
                MREQ: begin
                    if (mem.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        if (wen_q) begin
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_err_q   <= ERR_OK;
                            state_q      <= RESP;
                        end else begin
                            state_q <= MWAIT;
                        end
                    end else if (tmo_hit) begin
                        mem_valid_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                        resp_err_q   <= ERR_TMO;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                MWAIT: begin
                    if (mem.mem_rvalid) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= rdata_ext;
                        resp_err_q   <= ERR_OK;
                        state_q      <= RESP;
                    end else if (tmo_hit) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                        resp_err_q   <= ERR_TMO;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                RESP: if (exu.resp_ready) begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
